utmi_rx_sm_p: RTL and testbench
===============================

Name: utmi_rx_sm_p

Overview:
Parametrised successor to the UTMI receive state machine. Consumes decoded bytes from the shifter/NRZI stage, hunts SYNC, checks the PID, and streams packet bytes to the SIE with RX_ACTIVE/RX_VALID/RX_ERROR framing. Adds:
- selectable 8/16-bit SIE data path (RX_VALIDH);
- PID integrity check;
- babble (max-length) detection;
- bit-stuff error propagation.

Sits between the shifter and the SIE, in the same place as the existing RX state machine.

Parameters:
DATA_WIDTH, 8, SIE data width; legal values 8 or 16 only.
MAX_BYTES, 1027, max bytes after SYNC (PID+payload+CRC) before babble error.
SYNC_BYTE, 8'h2A, SYNC pattern as delivered by the shifter.
CNT_W, 11, width of RX_BYTE_CNT; must hold MAX_BYTES+1.

Ports:
CLK  input  1  single clock; all logic on posedge.
RST  input  1  synchronous, active-high reset.
SH_BYTE_VALID  input  1  SH_DATA_OUT holds a new byte this cycle.
SH_DATA_OUT  input  8  decoded byte from shifter.
SH_DATA_WAIT  input  1  bit-stuff stall; when 1 the byte is ignored even if SH_BYTE_VALID=1.
SH_EOP  input  1  EOP (SE0) detected, 1-cycle pulse.
SH_ERR  input  1  bit-stuff/line error, 1-cycle pulse.
RX_ACTIVE  output  1  packet in progress.
RX_VALID  output  1  SIE_DATA[7:0] valid, 1-cycle pulse.
RX_VALIDH  output  1  SIE_DATA[15:8] valid (tied 0 when DATA_WIDTH=8).
RX_ERROR  output  1  receive error, 1-cycle pulse.
SIE_DATA  output  DATA_WIDTH  received data, low byte first on the wire.
RX_BYTE_CNT  output  CNT_W  bytes accepted in current packet (PID included, SYNC excluded).

Behaviour:
- Byte acceptance: a byte is accepted when SH_BYTE_VALID=1 and SH_DATA_WAIT=0.
- Reset (RST=1 at a clock edge): state=IDLE. All outputs 0 the next cycle. Packer empty, RX_BYTE_CNT=0. Reset mid-packet aborts silently; no RX_ERROR.
- IDLE:
  - Accepted byte == SYNC_BYTE -> PID; RX_ACTIVE=1 from the next cycle.
  - Any other byte, SH_EOP or SH_ERR -> ignored.
- PID (first accepted byte after SYNC):
  - Byte is forwarded to the SIE like data.
  - If byte[3:0] == ~byte[7:4] -> DATA.
  - Otherwise -> ERR, with RX_ERROR pulsed in the same cycle the byte is presented.
  - SH_EOP in PID -> FLUSH; empty packet, no error.
- DATA: each accepted byte increments RX_BYTE_CNT.
  - 8-bit mode: byte appears on SIE_DATA with RX_VALID=1 exactly 1 cycle after acceptance.
  - 16-bit mode: first byte is held in the packer. Second byte -> SIE_DATA={b1,b0}, RX_VALID=RX_VALIDH=1, 1 cycle after the second byte is accepted.
  - SIE_DATA holds its last value between pulses.
- Babble: accepting a byte when RX_BYTE_CNT==MAX_BYTES -> byte dropped, RX_ERROR pulse next cycle, -> ERR.
- SH_ERR in PID or DATA: RX_ERROR pulse next cycle, packer cleared, -> ERR.
- SH_EOP in DATA (cycle N) -> FLUSH at N+1.
  - In FLUSH, a pending odd byte (16-bit mode) is output with RX_VALID=1, RX_VALIDH=0, SIE_DATA[15:8]=0.
  - RX_ACTIVE=0 at N+2; state IDLE at N+2.
- ERR: RX_ACTIVE held 1, bytes ignored, no further RX_VALID. SH_EOP -> FLUSH (no output) -> IDLE.
- Simultaneous events in one cycle:
  - accepted byte + SH_EOP: byte is processed first, then EOP takes effect.
  - SH_ERR + byte: SH_ERR wins and the byte is dropped.
  - SH_ERR + SH_EOP: error pulse, then -> FLUSH.
- RX_ERROR is never asserted in IDLE. RX_ERROR and RX_VALID are never both 1 in the same cycle, except the PID-error cycle (PID byte valid plus error).
- RX_BYTE_CNT clears on entry to IDLE. It saturates at MAX_BYTES.

Decomposition:
- Shared package utmi_pkg:
  - state encoding (IDLE, PID, DATA, ERR, FLUSH);
  - SYNC_BYTE default;
  - PID check function pid_ok(byte);
  - token PID constants (OUT=8'hE1, IN=8'h69, SETUP=8'h2D, DATA0=8'hC3, DATA1=8'h4B, ACK=8'hD2) for benches and the SIE.
- One sub-module, utmi_rx_pack: byte-to-word packer with flush. It is a pass-through register when DATA_WIDTH=8.

Test Plan:
1. DATA_WIDTH=8: bytes 2A, C3, 11, 22, then SH_EOP -> RX_ACTIVE rises the cycle after 2A. RX_VALID pulses carry C3, 11, 22, each 1 cycle after acceptance. RX_BYTE_CNT=3. RX_ACTIVE falls 2 cycles after SH_EOP. RX_ERROR never asserted.
2. DATA_WIDTH=16: bytes 2A, 4B, AA, BB, then SH_EOP -> words 16'hAA4B (VALID+VALIDH), then FLUSH outputs 16'h00BB (VALID=1, VALIDH=0).
3. Bad PID: 2A, C4 -> C4 forwarded with RX_VALID and RX_ERROR in the same cycle. Following bytes 55, 66 are not forwarded. RX_ACTIVE stays 1 until SH_EOP+2 cycles.
4. Babble with MAX_BYTES=4: 2A followed by 5 bytes -> 4 RX_VALID pulses, then RX_ERROR on the 5th. No RX_VALID for the 5th byte.
5. Stall and line error: SH_DATA_WAIT=1 with SH_BYTE_VALID=1 on byte 77 -> byte ignored, count unchanged. SH_ERR mid-DATA -> RX_ERROR next cycle and the pending odd byte is discarded.
6. RST asserted mid-DATA -> next cycle all outputs 0 and state IDLE. The following 2A, D2, SH_EOP is received normally.

Source files
------------

// File: rtl/utmi_pkg.sv
// Shared definitions for the UTMI receive path: state encoding, SYNC
// default, PID integrity check and the common token/handshake PIDs.
package utmi_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PID   = 3'd1,
    ST_DATA  = 3'd2,
    ST_ERR   = 3'd3,
    ST_FLUSH = 3'd4
  } rx_state_t;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'h2A;

  localparam logic [BYTE_W-1:0] PID_OUT   = 8'hE1;
  localparam logic [BYTE_W-1:0] PID_IN    = 8'h69;
  localparam logic [BYTE_W-1:0] PID_SETUP = 8'h2D;
  localparam logic [BYTE_W-1:0] PID_DATA0 = 8'hC3;
  localparam logic [BYTE_W-1:0] PID_DATA1 = 8'h4B;
  localparam logic [BYTE_W-1:0] PID_ACK   = 8'hD2;

  // Low nibble must be the bitwise complement of the high nibble.
  function automatic logic pid_ok(input logic [BYTE_W-1:0] b);
    return b[3:0] == ~b[7:4];
  endfunction

endpackage

// File: rtl/utmi_rx_pack.sv
// Byte-to-word packer feeding the SIE data bus.
// Ports:
//   clk_1, rst       clock and synchronous active-high reset
//   push, din        accept one byte into the packet stream
//   flush            emit any pending odd byte (high byte zeroed)
//   clear            drop any pending byte, no output
//   data, valid,     registered SIE word and its low/high byte strobes
//   validh
// With DATA_WIDTH=8 this is a plain one-stage pass-through register.
module utmi_rx_pack
  import utmi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_1,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  flush,
  input  logic                  clear,
  input  logic [BYTE_W-1:0]     din,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  validh
);

  if (DATA_WIDTH == 16) begin : g_w16
    logic [BYTE_W-1:0] held;
    logic              pending;

    // Pair bytes low-first; push together with flush and nothing pending
    // emits the new byte alone as a half word.
    always_ff @(posedge clk_1) begin
      if (rst) begin
        held    <= '0;
        pending <= 1'b0;
        data    <= '0;
        valid   <= 1'b0;
        validh  <= 1'b0;
      end else begin
        valid  <= 1'b0;
        validh <= 1'b0;
        if (clear) begin
          pending <= 1'b0;
        end else if (push && pending) begin
          data    <= {din, held};
          valid   <= 1'b1;
          validh  <= 1'b1;
          pending <= 1'b0;
        end else if (push && flush) begin
          data  <= {8'h00, din};
          valid <= 1'b1;
        end else if (push) begin
          held    <= din;
          pending <= 1'b1;
        end else if (flush && pending) begin
          data    <= {8'h00, held};
          valid   <= 1'b1;
          pending <= 1'b0;
        end
      end
    end
  end else begin : g_w8
    logic unused_flush;
    assign unused_flush = flush;
    assign validh       = 1'b0;

    always_ff @(posedge clk_1) begin
      if (rst) begin
        data  <= '0;
        valid <= 1'b0;
      end else begin
        valid <= push && !clear;
        if (push && !clear) data <= din;
      end
    end
  end

endmodule

// File: rtl/utmi_rx_sm_p.sv
// UTMI receive state machine: hunts SYNC, checks the PID, frames packet
// bytes to the SIE with RX_ACTIVE/RX_VALID/RX_VALIDH/RX_ERROR and detects
// babble and bit-stuff errors.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   SH_BYTE_VALID, SH_DATA_OUT,   byte stream from the shifter; a byte is
//   SH_DATA_WAIT                  taken only when valid and not stalled
//   SH_EOP, SH_ERR                end-of-packet and line-error pulses
//   RX_ACTIVE, RX_VALID,          registered SIE framing
//   RX_VALIDH, RX_ERROR
//   SIE_DATA                      received data, low byte first
//   RX_BYTE_CNT                   bytes accepted, PID included
module utmi_rx_sm_p
  import utmi_pkg::*;
#(
  parameter int unsigned       DATA_WIDTH = 8,
  parameter int unsigned       MAX_BYTES  = 1027,
  parameter logic [BYTE_W-1:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int unsigned       CNT_W      = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SH_BYTE_VALID,
  input  logic [BYTE_W-1:0]     SH_DATA_OUT,
  input  logic                  SH_DATA_WAIT,
  input  logic                  SH_EOP,
  input  logic                  SH_ERR,
  output logic                  RX_ACTIVE,
  output logic                  RX_VALID,
  output logic                  RX_VALIDH,
  output logic                  RX_ERROR,
  output logic [DATA_WIDTH-1:0] SIE_DATA,
  output logic [CNT_W-1:0]      RX_BYTE_CNT
);

  rx_state_t        state, state_d;
  logic [CNT_W-1:0] cnt_d;
  logic             err_d;
  logic             pk_push, pk_flush, pk_clear;
  logic             acc_c;
  logic             babble_c;

  assign acc_c    = SH_BYTE_VALID && !SH_DATA_WAIT;
  assign babble_c = (RX_BYTE_CNT == CNT_W'(MAX_BYTES));

  // Next state, counter and packer controls. Within one cycle a byte is
  // handled before EOP; SH_ERR overrides any byte.
  always_comb begin
    state_d  = state;
    cnt_d    = RX_BYTE_CNT;
    err_d    = 1'b0;
    pk_push  = 1'b0;
    pk_flush = 1'b0;
    pk_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc_c && (SH_DATA_OUT == SYNC_BYTE)) state_d = ST_PID;
      end
      ST_PID, ST_DATA: begin
        if (SH_ERR) begin
          err_d    = 1'b1;
          pk_clear = 1'b1;
          state_d  = SH_EOP ? ST_FLUSH : ST_ERR;
        end else begin
          if (acc_c) begin
            if (babble_c) begin
              err_d    = 1'b1;
              pk_clear = 1'b1;
              state_d  = ST_ERR;
            end else begin
              pk_push = 1'b1;
              cnt_d   = RX_BYTE_CNT + CNT_W'(1);
              if (state == ST_PID) begin
                if (pid_ok(SH_DATA_OUT)) begin
                  state_d = ST_DATA;
                end else begin
                  // Bad PID is still shown to the SIE, alongside the error.
                  err_d    = 1'b1;
                  pk_flush = 1'b1;
                  state_d  = ST_ERR;
                end
              end
            end
          end
          if (SH_EOP) begin
            pk_flush = 1'b1;
            state_d  = ST_FLUSH;
          end
        end
      end
      ST_ERR: begin
        if (SH_EOP) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_IDLE) cnt_d = '0;
  end

  // State and framing registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      RX_ACTIVE   <= 1'b0;
      RX_ERROR    <= 1'b0;
      RX_BYTE_CNT <= '0;
    end else begin
      state       <= state_d;
      RX_ACTIVE   <= (state_d != ST_IDLE);
      RX_ERROR    <= err_d;
      RX_BYTE_CNT <= cnt_d;
    end
  end

  utmi_rx_pack #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pack (
    .clk_1  (CLK),
    .rst    (RST),
    .push   (pk_push),
    .flush  (pk_flush),
    .clear  (pk_clear),
    .din    (SH_DATA_OUT),
    .data   (SIE_DATA),
    .valid  (RX_VALID),
    .validh (RX_VALIDH)
  );

endmodule

// File: tb/tb_utmi_rx_sm_p.sv
// Directed bench for utmi_rx_sm_p: three instances (8-bit, 16-bit,
// 8-bit with MAX_BYTES=4) share one shifter-side stimulus stream.
module tb_utmi_rx_sm_p;

  logic       clk = 1'b0;
  logic       rst;
  logic       sh_valid, sh_wait, sh_eop, sh_err;
  logic [7:0] sh_data;

  logic        a8, v8, vh8, e8;
  logic [7:0]  d8;
  logic [10:0] c8;
  logic        a16, v16, vh16, e16;
  logic [15:0] d16;
  logic [10:0] c16;
  logic        ab, vb, vhb, eb;
  logic [7:0]  db;
  logic [10:0] cb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  utmi_rx_sm_p #(.DATA_WIDTH(8)) u8 (
    .CLK(clk), .RST(rst), .SH_BYTE_VALID(sh_valid), .SH_DATA_OUT(sh_data),
    .SH_DATA_WAIT(sh_wait), .SH_EOP(sh_eop), .SH_ERR(sh_err),
    .RX_ACTIVE(a8), .RX_VALID(v8), .RX_VALIDH(vh8), .RX_ERROR(e8),
    .SIE_DATA(d8), .RX_BYTE_CNT(c8));

  utmi_rx_sm_p #(.DATA_WIDTH(16)) u16 (
    .CLK(clk), .RST(rst), .SH_BYTE_VALID(sh_valid), .SH_DATA_OUT(sh_data),
    .SH_DATA_WAIT(sh_wait), .SH_EOP(sh_eop), .SH_ERR(sh_err),
    .RX_ACTIVE(a16), .RX_VALID(v16), .RX_VALIDH(vh16), .RX_ERROR(e16),
    .SIE_DATA(d16), .RX_BYTE_CNT(c16));

  utmi_rx_sm_p #(.DATA_WIDTH(8), .MAX_BYTES(4)) ub (
    .CLK(clk), .RST(rst), .SH_BYTE_VALID(sh_valid), .SH_DATA_OUT(sh_data),
    .SH_DATA_WAIT(sh_wait), .SH_EOP(sh_eop), .SH_ERR(sh_err),
    .RX_ACTIVE(ab), .RX_VALID(vb), .RX_VALIDH(vhb), .RX_ERROR(eb),
    .SIE_DATA(db), .RX_BYTE_CNT(cb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of shifter inputs, then sample just after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic w,
                     input logic e, input logic r);
    @(negedge clk);
    sh_valid = v; sh_data = d; sh_wait = w; sh_eop = e; sh_err = r;
    @(posedge clk);
    #1;
  endtask

  task automatic byte_in(input logic [7:0] d); cyc(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic idle();                      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask
  task automatic eop();                       cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sh_valid = 1'b0; sh_data = 8'h00; sh_wait = 1'b0;
    sh_eop = 1'b0; sh_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_active",  32'(a8),  0);
    chk("rst_valid",   32'(v8),  0);
    chk("rst_error",   32'(e8),  0);
    chk("rst_data16",  32'(d16), 0);
    chk("rst_validh",  32'(vh16), 0);
    chk("rst_cnt",     32'(c8),  0);
    @(negedge clk); rst = 1'b0;

    // 1: 8-bit basic packet
    byte_in(8'h2A);
    chk("t1_active_rise", 32'(a8), 1);
    chk("t1_no_valid_sync", 32'(v8), 0);
    byte_in(8'hC3);
    chk("t1_v0", 32'(v8), 1); chk("t1_d0", 32'(d8), 'hC3); chk("t1_c0", 32'(c8), 1);
    byte_in(8'h11);
    chk("t1_v1", 32'(v8), 1); chk("t1_d1", 32'(d8), 'h11);
    byte_in(8'h22);
    chk("t1_v2", 32'(v8), 1); chk("t1_d2", 32'(d8), 'h22); chk("t1_cnt", 32'(c8), 3);
    chk("t1_err", 32'(e8), 0);
    eop();
    chk("t1_active_flush", 32'(a8), 1); chk("t1_no_valid_flush", 32'(v8), 0);
    idle();
    chk("t1_active_fall", 32'(a8), 0); chk("t1_cnt_clr", 32'(c8), 0);
    chk("t1_err_end", 32'(e8), 0);

    // 2: 16-bit packing and odd-byte flush
    byte_in(8'h2A);
    byte_in(8'h4B);
    chk("t2_pend_novalid", 32'(v16), 0);
    byte_in(8'hAA);
    chk("t2_w0_v", 32'(v16), 1); chk("t2_w0_vh", 32'(vh16), 1);
    chk("t2_w0_d", 32'(d16), 'hAA4B);
    byte_in(8'hBB);
    chk("t2_pend2", 32'(v16), 0); chk("t2_hold", 32'(d16), 'hAA4B);
    eop();
    chk("t2_fl_v", 32'(v16), 1); chk("t2_fl_vh", 32'(vh16), 0);
    chk("t2_fl_d", 32'(d16), 'h00BB); chk("t2_fl_active", 32'(a16), 1);
    idle();
    chk("t2_active_fall", 32'(a16), 0); chk("t2_end_valid", 32'(v16), 0);

    // 3: bad PID
    byte_in(8'h2A);
    byte_in(8'hC4);
    chk("t3_pid_v", 32'(v8), 1); chk("t3_pid_d", 32'(d8), 'hC4);
    chk("t3_pid_err", 32'(e8), 1);
    byte_in(8'h55);
    chk("t3_drop_v", 32'(v8), 0); chk("t3_err_once", 32'(e8), 0);
    chk("t3_active", 32'(a8), 1);
    byte_in(8'h66);
    chk("t3_drop_v2", 32'(v8), 0);
    eop();
    chk("t3_active_flush", 32'(a8), 1); chk("t3_flush_nov", 32'(v8), 0);
    idle();
    chk("t3_active_fall", 32'(a8), 0);

    // 4: babble on the MAX_BYTES=4 instance
    byte_in(8'h2A);
    for (int i = 0; i < 4; i++) begin
      byte_in(8'(8'hC3 + i));
      chk("t4_valid", 32'(vb), 1);
      chk("t4_data", 32'(db), 32'(8'(8'hC3 + i)));
      chk("t4_noerr", 32'(eb), 0);
    end
    chk("t4_cnt_max", 32'(cb), 4);
    byte_in(8'h77);
    chk("t4_bab_nov", 32'(vb), 0); chk("t4_bab_err", 32'(eb), 1);
    chk("t4_cnt_sat", 32'(cb), 4);
    idle();
    chk("t4_err_pulse", 32'(eb), 0); chk("t4_active_err", 32'(ab), 1);
    eop();
    chk("t4_active_flush", 32'(ab), 1);
    idle();
    chk("t4_active_fall", 32'(ab), 0);

    // 5: stall and line error
    byte_in(8'h2A);
    byte_in(8'hC3);
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("t5_stall_nov", 32'(v8), 0); chk("t5_stall_cnt", 32'(c8), 1);
    byte_in(8'h88);
    chk("t5_v8", 32'(v8), 1); chk("t5_d8", 32'(d8), 'h88); chk("t5_c8", 32'(c8), 2);
    chk("t5_w16", 32'(d16), 'h88C3);
    byte_in(8'h99);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t5_err16", 32'(e16), 1); chk("t5_nov16", 32'(v16), 0);
    chk("t5_err8", 32'(e8), 1);
    idle();
    chk("t5_err_pulse", 32'(e16), 0); chk("t5_active_err", 32'(a16), 1);
    eop();
    chk("t5_discard", 32'(v16), 0);
    idle();
    chk("t5_active_fall", 32'(a16), 0);

    // 6: reset mid-packet, then a clean handshake packet
    byte_in(8'h2A);
    byte_in(8'hC3);
    byte_in(8'h11);
    @(negedge clk); rst = 1'b1; sh_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_active", 32'(a8), 0); chk("t6_valid", 32'(v8), 0);
    chk("t6_error", 32'(e8), 0); chk("t6_data", 32'(d8), 0);
    chk("t6_cnt", 32'(c8), 0); chk("t6_data16", 32'(d16), 0);
    @(negedge clk); rst = 1'b0;
    byte_in(8'h2A);
    chk("t6_active_rise", 32'(a8), 1);
    byte_in(8'hD2);
    chk("t6_ack_v", 32'(v8), 1); chk("t6_ack_d", 32'(d8), 'hD2);
    chk("t6_ack_err", 32'(e8), 0); chk("t6_ack_cnt", 32'(c8), 1);
    eop();
    chk("t6_active_flush", 32'(a8), 1);
    idle();
    chk("t6_active_fall", 32'(a8), 0); chk("t6_cnt_clr", 32'(c8), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
